// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD SPI-mode command controller: command indices,
// R1 flag positions, card states and response buffer types.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam int R1_CRC_BIT     = 3;
    localparam int R1_PARAM_BIT   = 6;

    localparam logic [7:0] R1_F_NONE    = 8'h00;
    localparam logic [7:0] R1_F_ILLEGAL = 8'(1 << R1_ILLEGAL_BIT);
    localparam logic [7:0] R1_F_CRC     = 8'(1 << R1_CRC_BIT);
    localparam logic [7:0] R1_F_PARAM   = 8'(1 << R1_PARAM_BIT);

    // R3 and R7 are both one R1 byte followed by four payload bytes.
    localparam logic [2:0] RESP_LEN_R1   = 3'd1;
    localparam logic [2:0] RESP_LEN_LONG = 3'd5;
    localparam int         RESP_MAX_BYTES = 5;

    typedef enum logic [1:0] {
        S_PWRUP = 2'd0,
        S_IDLE  = 2'd1,
        S_READY = 2'd2
    } card_state_t;

    // Index 0 is the first byte on the wire.
    typedef logic [RESP_MAX_BYTES-1:0][7:0] resp_buf_t;

    function automatic logic [7:0] r1_byte(input logic idle, input logic [7:0] flags);
        return flags | (8'(idle) << R1_IDLE_BIT);
    endfunction

endpackage

// File: rtl/sd_spi_card_ctrl_if.sv
// Bus bundle between the SPI receiver/transmitter and the card controller.
// The controller uses the slave modport; the surrounding SPI logic uses master.
interface sd_spi_card_ctrl_if #(
    parameter int BLKLEN_W = 12
);
    logic                io_ArgumentReadFinished;
    logic                io_ReadSuccess;
    logic [5:0]          io_Command;
    logic [31:0]         io_CommandArgument;
    logic                io_RespReady;
    logic                io_RespValid;
    logic [7:0]          io_RespData;
    logic                io_RespLast;
    logic [BLKLEN_W-1:0] io_DataBlockSize;
    logic                io_CardIdle;
    logic                io_CardReady;
    logic                io_AppCmd;
    logic                io_Overrun;

    modport slave (
        input  io_ArgumentReadFinished, io_ReadSuccess, io_Command, io_CommandArgument,
        input  io_RespReady,
        output io_RespValid, io_RespData, io_RespLast, io_DataBlockSize,
        output io_CardIdle, io_CardReady, io_AppCmd, io_Overrun
    );

    modport master (
        output io_ArgumentReadFinished, io_ReadSuccess, io_Command, io_CommandArgument,
        output io_RespReady,
        input  io_RespValid, io_RespData, io_RespLast, io_DataBlockSize,
        input  io_CardIdle, io_CardReady, io_AppCmd, io_Overrun
    );
endinterface

// File: rtl/sd_resp_serializer.sv
// Five-byte load-parallel response buffer; shifts out one byte per valid&&ready
// handshake and flags the final byte.
module sd_resp_serializer
    import sd_spi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  resp_buf_t  load_bytes,
    input  logic [2:0] load_len,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data,
    output logic       last
);

    resp_buf_t  bytes_q, bytes_d;
    logic [2:0] cnt_q, cnt_d;

    assign valid = (cnt_q != 3'd0);
    assign last  = (cnt_q == 3'd1);
    assign data  = valid ? bytes_q[0] : 8'hFF;

    // A load always wins: the controller only loads once the old response is gone.
    always_comb begin
        bytes_d = bytes_q;
        cnt_d   = cnt_q;
        if (load) begin
            bytes_d = load_bytes;
            cnt_d   = load_len;
        end else if (valid && ready) begin
            bytes_d = {8'hFF, bytes_q[RESP_MAX_BYTES-1:1]};
            cnt_d   = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bytes_q <= '1;
            cnt_q   <= 3'd0;
        end else begin
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_spi_card_ctrl.sv
// SD SPI-mode command controller: card state machine, R1/R7 response build, block length.
// Optional SD_CMD58_OCR_EN: answer CMD58 with a five-byte R3 carrying the OCR.
module sd_spi_card_ctrl
    import sd_spi_pkg::*;
#(
    parameter int BLKLEN_W     = 12,
    parameter int DEF_BLKLEN   = 512,
    parameter int MAX_BLKLEN   = 2048,
    parameter int ACMD41_COUNT = 2
) (
    input logic               clock,
    input logic               reset,
    sd_spi_card_ctrl_if.slave bus
);

`ifdef SD_CMD58_OCR_EN
    localparam logic [31:0] OCR_BASE = 32'h00FF_8000;
`endif

    card_state_t         state_q, state_d;
    logic                app_cmd_q, app_cmd_d;
    logic [3:0]          acmd_cnt_q, acmd_cnt_d, acmd_cnt_inc;
    logic [BLKLEN_W-1:0] blklen_q, blklen_d;
    logic                overrun_q, overrun_d;
    logic                arf_prev_q;

    logic                evt, pending, accept, idle;
    logic [5:0]          cmd;
    logic [31:0]         arg;
    logic                load;
    resp_buf_t           load_bytes;
    logic [2:0]          load_len;
    logic                resp_valid, resp_last;
    logic [7:0]          resp_data;
`ifdef SD_CMD58_OCR_EN
    logic [31:0]         ocr;
`endif

    assign cmd = bus.io_Command;
    assign arg = bus.io_CommandArgument;

    // A response still owns the buffer unless its last byte leaves this very cycle.
    always_comb begin
        evt          = bus.io_ArgumentReadFinished && !arf_prev_q;
        pending      = resp_valid && !(bus.io_RespReady && resp_last);
        accept       = evt && !pending;
        idle         = (state_q == S_IDLE);
        acmd_cnt_inc = (acmd_cnt_q == 4'hF) ? acmd_cnt_q : acmd_cnt_q + 4'd1;

        state_d    = state_q;
        app_cmd_d  = app_cmd_q;
        acmd_cnt_d = acmd_cnt_q;
        blklen_d   = blklen_q;
        overrun_d  = evt && pending;
        load       = 1'b0;
        load_len   = RESP_LEN_R1;
        load_bytes = '1;
`ifdef SD_CMD58_OCR_EN
        ocr = OCR_BASE | {{2{state_q == S_READY}}, 30'd0};
`endif

        if (accept) begin
            if (!bus.io_ReadSuccess) begin
                if (state_q != S_PWRUP) begin
                    load          = 1'b1;
                    load_bytes[0] = r1_byte(idle, R1_F_CRC);
                    app_cmd_d     = 1'b0;
                end
            end else if (state_q != S_PWRUP || cmd == CMD0) begin
                load      = 1'b1;
                app_cmd_d = 1'b0;
                case (cmd)
                    CMD0: begin
                        state_d       = S_IDLE;
                        acmd_cnt_d    = 4'd0;
                        blklen_d      = BLKLEN_W'(DEF_BLKLEN);
                        load_bytes[0] = r1_byte(1'b1, R1_F_NONE);
                    end
                    CMD8: begin
                        load_len   = RESP_LEN_LONG;
                        load_bytes = {arg[7:0], {4'h0, arg[11:8]}, 8'h00, 8'h00,
                                      r1_byte(idle, R1_F_NONE)};
                    end
                    CMD16: begin
                        if (arg != 32'd0 && arg <= 32'(MAX_BLKLEN)) begin
                            blklen_d      = arg[BLKLEN_W-1:0];
                            load_bytes[0] = r1_byte(idle, R1_F_NONE);
                        end else begin
                            load_bytes[0] = r1_byte(idle, R1_F_PARAM);
                        end
                    end
                    CMD55: begin
                        app_cmd_d     = 1'b1;
                        load_bytes[0] = r1_byte(idle, R1_F_NONE);
                    end
                    CMD41: begin
                        if (!app_cmd_q) begin
                            load_bytes[0] = r1_byte(idle, R1_F_ILLEGAL);
                        end else if (state_q == S_IDLE) begin
                            acmd_cnt_d = acmd_cnt_inc;
                            if (acmd_cnt_inc >= 4'(ACMD41_COUNT)) begin
                                state_d       = S_READY;
                                load_bytes[0] = r1_byte(1'b0, R1_F_NONE);
                            end else begin
                                load_bytes[0] = r1_byte(1'b1, R1_F_NONE);
                            end
                        end else begin
                            load_bytes[0] = r1_byte(1'b0, R1_F_NONE);
                        end
                    end
`ifdef SD_CMD58_OCR_EN
                    CMD58: begin
                        load_len   = RESP_LEN_LONG;
                        load_bytes = {ocr[7:0], ocr[15:8], ocr[23:16], ocr[31:24],
                                      r1_byte(idle, R1_F_NONE)};
                    end
`else
                    CMD58: begin
                        load_bytes[0] = r1_byte(idle, R1_F_ILLEGAL);
                    end
`endif
                    default: begin
                        load_bytes[0] = r1_byte(idle, R1_F_ILLEGAL);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_PWRUP;
            app_cmd_q  <= 1'b0;
            acmd_cnt_q <= 4'd0;
            blklen_q   <= BLKLEN_W'(DEF_BLKLEN);
            overrun_q  <= 1'b0;
            arf_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            app_cmd_q  <= app_cmd_d;
            acmd_cnt_q <= acmd_cnt_d;
            blklen_q   <= blklen_d;
            overrun_q  <= overrun_d;
            arf_prev_q <= bus.io_ArgumentReadFinished;
        end
    end

    sd_resp_serializer u_ser (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_bytes (load_bytes),
        .load_len   (load_len),
        .ready      (bus.io_RespReady),
        .valid      (resp_valid),
        .data       (resp_data),
        .last       (resp_last)
    );

    assign bus.io_RespValid     = resp_valid;
    assign bus.io_RespData      = resp_data;
    assign bus.io_RespLast      = resp_last;
    assign bus.io_DataBlockSize = blklen_q;
    assign bus.io_CardIdle      = (state_q == S_IDLE);
    assign bus.io_CardReady     = (state_q == S_READY);
    assign bus.io_AppCmd        = app_cmd_q;
    assign bus.io_Overrun       = overrun_q;

endmodule

// File: tb/tb_sd_spi_card_ctrl.sv
// Self-checking bench for sd_spi_card_ctrl: expected response bytes go into a
// scoreboard queue as commands are issued and are compared against captured bytes.
module tb_sd_spi_card_ctrl;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sd_spi_card_ctrl_if #(.BLKLEN_W(12)) bus ();

    sd_spi_card_ctrl #(
        .BLKLEN_W     (12),
        .DEF_BLKLEN   (512),
        .MAX_BLKLEN   (2048),
        .ACMD41_COUNT (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int stall_bad;
    int drain_timeout;
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];

    task automatic push(input logic [7:0] b, input logic last);
        exp_q.push_back({last, b});
    endtask

    // Drives one frame; returns 1ns after the clock edge that sees the rising event.
    task automatic send_frame(input logic [5:0] cmd, input logic [31:0] arg, input logic ok);
        @(posedge clock); #1;
        bus.io_Command            = cmd;
        bus.io_CommandArgument    = arg;
        bus.io_ReadSuccess        = ok;
        bus.io_ArgumentReadFinished = 1'b1;
        @(posedge clock); #1;
        bus.io_ArgumentReadFinished = 1'b0;
    endtask

    // Monitor: captures every handshaked byte; notes stall instability and runaway responses.
    task automatic drain(input bit toggle);
        int cyc = 0;
        bit done = 0;
        bit stalled = 0;
        logic [8:0] held = '0;
        while (!done) begin
            bus.io_RespReady = toggle ? (cyc % 2 == 1) : 1'b1;
            @(negedge clock);
            if (!bus.io_RespValid) begin
                done = 1;
            end else begin
                if (stalled && {bus.io_RespLast, bus.io_RespData} !== held) stall_bad++;
                if (bus.io_RespReady) begin
                    rx_q.push_back({bus.io_RespLast, bus.io_RespData});
                    stalled = 0;
                end else begin
                    held = {bus.io_RespLast, bus.io_RespData};
                    stalled = 1;
                end
                @(posedge clock); #1;
                cyc++;
                if (cyc > 40) begin
                    drain_timeout++;
                    done = 1;
                end
            end
        end
        bus.io_RespReady = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic ok, input bit toggle);
        send_frame(cmd, arg, ok);
        drain(toggle);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.io_ArgumentReadFinished = 1'b0;
        bus.io_ReadSuccess = 1'b0;
        bus.io_Command = 6'd0;
        bus.io_CommandArgument = 32'd0;
        bus.io_RespReady = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        total++; if (bus.io_RespValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.io_RespValid); end
        total++; if (bus.io_RespData !== 8'hFF) begin bad++; $display("[TB] FAIL reset_data got=%h want=ff", bus.io_RespData); end
        total++; if (bus.io_RespLast !== 1'b0) begin bad++; $display("[TB] FAIL reset_last got=%b want=0", bus.io_RespLast); end
        total++; if (bus.io_DataBlockSize !== 12'd512) begin bad++; $display("[TB] FAIL reset_blklen got=%0d want=512", bus.io_DataBlockSize); end
        total++; if ({bus.io_CardIdle, bus.io_CardReady, bus.io_AppCmd, bus.io_Overrun} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {bus.io_CardIdle, bus.io_CardReady, bus.io_AppCmd, bus.io_Overrun});
        end
        send_frame(6'd8, 32'h0000_01AA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++; if (bus.io_RespValid !== 1'b0) begin bad++; $display("[TB] FAIL pwrup_cmd8_valid got=%b want=0", bus.io_RespValid); end
        end
        total++; if ({bus.io_CardIdle, bus.io_CardReady} !== 2'b00) begin bad++; $display("[TB] FAIL pwrup_state got=%b want=00", {bus.io_CardIdle, bus.io_CardReady}); end
    endtask

    task automatic test_cmd0_cmd8();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
        push(8'h01, 1'b1);
        send_frame(6'd0, 32'd0, 1'b1);
        total++; if (bus.io_RespValid !== 1'b1) begin bad++; $display("[TB] FAIL cmd0_latency got=%b want=1", bus.io_RespValid); end
        drain(1'b0);
        total++; if (bus.io_CardIdle !== 1'b1) begin bad++; $display("[TB] FAIL cmd0_idle got=%b want=1", bus.io_CardIdle); end
        push(8'h01, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'hAA, 1'b1);
        run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1);
        push(8'h01, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h03, 1'b0); push(8'h5A, 1'b1);
        run_cmd(6'd8, 32'hFFFF_F35A, 1'b1, 1'b1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL cmd0_cmd8_byte got=%h want=%h", g, e); end
        end
        total++; if (rx_q.size() != 0 || stall_bad != 0 || drain_timeout != 0) begin
            bad++; $display("[TB] FAIL cmd8_stream extra=%0d unstable=%0d timeouts=%0d want 0/0/0", rx_q.size(), stall_bad, drain_timeout);
        end
    endtask

    task automatic test_cmd16();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
        push(8'h01, 1'b1); run_cmd(6'd55, 32'd0, 1'b1, 1'b0);
        total++; if (bus.io_AppCmd !== 1'b1) begin bad++; $display("[TB] FAIL cmd55_app got=%b want=1", bus.io_AppCmd); end
        push(8'h01, 1'b1); run_cmd(6'd55, 32'd0, 1'b1, 1'b0);
        total++; if (bus.io_AppCmd !== 1'b1) begin bad++; $display("[TB] FAIL cmd55x2_app got=%b want=1", bus.io_AppCmd); end
        push(8'h01, 1'b1); run_cmd(6'd16, 32'd1024, 1'b1, 1'b0);
        total++; if (bus.io_AppCmd !== 1'b0) begin bad++; $display("[TB] FAIL cmd16_app got=%b want=0", bus.io_AppCmd); end
        total++; if (bus.io_DataBlockSize !== 12'd1024) begin bad++; $display("[TB] FAIL blklen_1024 got=%0d want=1024", bus.io_DataBlockSize); end
        push(8'h41, 1'b1); run_cmd(6'd16, 32'd4096, 1'b1, 1'b0);
        push(8'h41, 1'b1); run_cmd(6'd16, 32'd0, 1'b1, 1'b0);
        total++; if (bus.io_DataBlockSize !== 12'd1024) begin bad++; $display("[TB] FAIL blklen_kept got=%0d want=1024", bus.io_DataBlockSize); end
        push(8'h01, 1'b1); run_cmd(6'd16, 32'd2048, 1'b1, 1'b0);
        total++; if (bus.io_DataBlockSize !== 12'd2048) begin bad++; $display("[TB] FAIL blklen_max got=%0d want=2048", bus.io_DataBlockSize); end
        push(8'h41, 1'b1); run_cmd(6'd16, 32'd2049, 1'b1, 1'b0);
        push(8'h01, 1'b1); run_cmd(6'd16, 32'd1, 1'b1, 1'b0);
        total++; if (bus.io_DataBlockSize !== 12'd1) begin bad++; $display("[TB] FAIL blklen_min got=%0d want=1", bus.io_DataBlockSize); end
        push(8'h01, 1'b1); run_cmd(6'd16, 32'd512, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL cmd16_byte got=%h want=%h", g, e); end
        end
        total++; if (rx_q.size() != 0 || drain_timeout != 0) begin bad++; $display("[TB] FAIL cmd16_stream extra=%0d timeouts=%0d want 0/0", rx_q.size(), drain_timeout); end
    endtask

    task automatic test_bad_crc();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
        push(8'h01, 1'b1); run_cmd(6'd55, 32'd0, 1'b1, 1'b0);
        push(8'h09, 1'b1); run_cmd(6'd16, 32'd8, 1'b0, 1'b0);
        total++; if (bus.io_AppCmd !== 1'b0) begin bad++; $display("[TB] FAIL crc_app got=%b want=0", bus.io_AppCmd); end
        total++; if (bus.io_DataBlockSize !== 12'd512) begin bad++; $display("[TB] FAIL crc_blklen got=%0d want=512", bus.io_DataBlockSize); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL crc_byte got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_overrun();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
        push(8'h01, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h02, 1'b0); push(8'hFF, 1'b1);
        bus.io_RespReady = 1'b0;
        send_frame(6'd8, 32'h0000_02FF, 1'b1);
        send_frame(6'd16, 32'd8, 1'b1);
        total++; if (bus.io_Overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_pulse got=%b want=1", bus.io_Overrun); end
        @(posedge clock); #1;
        total++; if (bus.io_Overrun !== 1'b0) begin bad++; $display("[TB] FAIL overrun_clear got=%b want=0", bus.io_Overrun); end
        total++; if (bus.io_DataBlockSize !== 12'd512) begin bad++; $display("[TB] FAIL overrun_blklen got=%0d want=512", bus.io_DataBlockSize); end
        drain(1'b1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL overrun_byte got=%h want=%h", g, e); end
        end
        total++; if (rx_q.size() != 0 || stall_bad != 0) begin bad++; $display("[TB] FAIL overrun_stream extra=%0d unstable=%0d want 0/0", rx_q.size(), stall_bad); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
        @(posedge clock); #1;
        bus.io_Command = 6'd55; bus.io_CommandArgument = 32'd0; bus.io_ReadSuccess = 1'b1;
        bus.io_ArgumentReadFinished = 1'b1; bus.io_RespReady = 1'b0;
        @(posedge clock); #1;
        bus.io_ArgumentReadFinished = 1'b0;
        total++; if ({bus.io_RespValid, bus.io_RespLast, bus.io_RespData} !== 10'h301) begin
            bad++; $display("[TB] FAIL b2b_first got=%h want=301", {bus.io_RespValid, bus.io_RespLast, bus.io_RespData});
        end
        @(posedge clock); #1;
        bus.io_Command = 6'd16; bus.io_CommandArgument = 32'd4096;
        bus.io_ArgumentReadFinished = 1'b1; bus.io_RespReady = 1'b1;
        @(posedge clock); #1;
        bus.io_ArgumentReadFinished = 1'b0; bus.io_RespReady = 1'b0;
        total++; if (bus.io_Overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun got=%b want=0", bus.io_Overrun); end
        push(8'h41, 1'b1);
        drain(1'b0);
        total++; if (bus.io_AppCmd !== 1'b0) begin bad++; $display("[TB] FAIL b2b_app got=%b want=0", bus.io_AppCmd); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL b2b_byte got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_acmd41();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
        push(8'h05, 1'b1); run_cmd(6'd41, 32'd0, 1'b1, 1'b0);
        push(8'h01, 1'b1); run_cmd(6'd55, 32'd0, 1'b1, 1'b0);
        push(8'h01, 1'b1); run_cmd(6'd41, 32'h4000_0000, 1'b1, 1'b0);
        total++; if ({bus.io_CardIdle, bus.io_CardReady} !== 2'b10) begin bad++; $display("[TB] FAIL acmd41_first got=%b want=10", {bus.io_CardIdle, bus.io_CardReady}); end
        push(8'h01, 1'b1); run_cmd(6'd55, 32'd0, 1'b1, 1'b0);
        push(8'h00, 1'b1); run_cmd(6'd41, 32'h4000_0000, 1'b1, 1'b0);
        total++; if ({bus.io_CardIdle, bus.io_CardReady} !== 2'b01) begin bad++; $display("[TB] FAIL acmd41_ready got=%b want=01", {bus.io_CardIdle, bus.io_CardReady}); end
        push(8'h00, 1'b1); run_cmd(6'd55, 32'd0, 1'b1, 1'b0);
        push(8'h00, 1'b1); run_cmd(6'd41, 32'd0, 1'b1, 1'b0);
        push(8'h04, 1'b1); run_cmd(6'd17, 32'd0, 1'b1, 1'b0);
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'hAA, 1'b1);
        run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL acmd41_byte got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_cmd58();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
`ifdef SD_CMD58_OCR_EN
        push(8'h00, 1'b0); push(8'hC0, 1'b0); push(8'hFF, 1'b0); push(8'h80, 1'b0); push(8'h00, 1'b1);
`else
        push(8'h04, 1'b1);
`endif
        run_cmd(6'd58, 32'd0, 1'b1, 1'b1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL cmd58_byte got=%h want=%h", g, e); end
        end
        total++; if (rx_q.size() != 0 || stall_bad != 0) begin bad++; $display("[TB] FAIL cmd58_stream extra=%0d unstable=%0d want 0/0", rx_q.size(), stall_bad); end
    endtask

    task automatic test_reset_mid_drain();
        logic [8:0] e, g;
        stall_bad = 0; drain_timeout = 0; rx_q.delete();
        send_frame(6'd8, 32'h0000_01AA, 1'b1);
        bus.io_RespReady = 1'b1;
        @(posedge clock); #3;
        total++; if (bus.io_RespValid !== 1'b1) begin bad++; $display("[TB] FAIL middrain_valid got=%b want=1", bus.io_RespValid); end
        reset = 1'b1;
        #1;
        total++; if ({bus.io_RespValid, bus.io_RespLast, bus.io_RespData} !== 10'h0FF) begin
            bad++; $display("[TB] FAIL async_resp got=%h want=0ff", {bus.io_RespValid, bus.io_RespLast, bus.io_RespData});
        end
        total++; if ({bus.io_CardIdle, bus.io_CardReady, bus.io_AppCmd} !== 3'b000) begin
            bad++; $display("[TB] FAIL async_state got=%b want=000", {bus.io_CardIdle, bus.io_CardReady, bus.io_AppCmd});
        end
        total++; if (bus.io_DataBlockSize !== 12'd512) begin bad++; $display("[TB] FAIL async_blklen got=%0d want=512", bus.io_DataBlockSize); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        bus.io_RespReady = 1'b0;
        send_frame(6'd55, 32'd0, 1'b1);
        @(negedge clock);
        total++; if (bus.io_RespValid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_quiet got=%b want=0", bus.io_RespValid); end
        push(8'h01, 1'b1); run_cmd(6'd0, 32'd0, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() != 0) g = rx_q.pop_front(); else g = 9'bx;
            total++; if (g !== e) begin bad++; $display("[TB] FAIL post_reset_cmd0 got=%h want=%h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_cmd0_cmd8();
        test_cmd16();
        test_bad_crc();
        test_overrun();
        test_back_to_back();
        test_acmd41();
        test_cmd58();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
